// File: rtl/alu_pkg.sv
// Shared types and command decode helpers for the ALU result collector.
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 8;
  localparam int unsigned ALU_CWIDTH = 4;
  localparam int unsigned RES_W      = ALU_WIDTH + 2;

  // Multiply commands (arithmetic mode) take three cycles to produce a result.
  localparam logic [ALU_CWIDTH-1:0] CmdMulA = ALU_CWIDTH'(9);
  localparam logic [ALU_CWIDTH-1:0] CmdMulB = ALU_CWIDTH'(10);

  // Bit n set means command n needs both operands.
  localparam logic [2**ALU_CWIDTH-1:0] TwoOpArith = 16'h070F;  // 0-3, 8-10
  localparam logic [2**ALU_CWIDTH-1:0] TwoOpLogic = 16'h303F;  // 0-5, 12, 13

  typedef struct packed {
    logic [RES_W-1:0]      res;
    logic [5:0]            flags;    // {COUT, OFLOW, E, G, L, ERR}
    logic [ALU_CWIDTH-1:0] cmd;
    logic                  mode;
    logic                  timeout;
  } alu_rec_t;

  typedef struct packed {
    logic                  valid;
    logic [ALU_CWIDTH-1:0] cmd;
    logic                  mode;
    logic                  timeout;
  } slot_t;

  function automatic logic is_two_op(input logic mode, input logic [ALU_CWIDTH-1:0] cmd);
    logic [2**ALU_CWIDTH-1:0] mask;
    mask = mode ? TwoOpArith : TwoOpLogic;
    return mask[cmd];
  endfunction

  // Cycles from issue to the cycle the result is valid on RES.
  function automatic logic [1:0] op_latency(input logic mode, input logic [ALU_CWIDTH-1:0] cmd);
    if (mode && (cmd == CmdMulA || cmd == CmdMulB)) return 2'd3;
    return 2'd1;
  endfunction

endpackage

// File: rtl/alu_rec_fifo.sv
// Synchronous FIFO of tagged ALU result records; no read bypass.
module alu_rec_fifo import alu_pkg::*; #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  alu_rec_t               wdata_i,
  input  logic                   pop_i,
  output alu_rec_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam logic [FW-1:0] DepthVal = FW'(DEPTH);

  alu_rec_t      mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          wr_en, rd_en;

  assign full_o  = (fill_q == DepthVal);
  assign empty_o = (fill_q == '0);
  assign rd_en   = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full_o || rd_en);

  // Next-state for pointers and occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

  // Storage array; contents are masked at the output while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign fill_o  = fill_q;

endmodule

// File: rtl/alu_result_collector.sv
// Tracks ALU issues, captures results at their latency, and queues tagged records.
module alu_result_collector import alu_pkg::*; #(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned CWIDTH  = ALU_CWIDTH,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CE,
  input  logic                   MODE,
  input  logic [CWIDTH-1:0]      CMD,
  input  logic [1:0]             INP_VALID,
  input  logic [WIDTH+1:0]       RES,
  input  logic                   COUT,
  input  logic                   OFLOW,
  input  logic                   E,
  input  logic                   G,
  input  logic                   L,
  input  logic                   ERR,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+1:0]       out_res,
  output logic [5:0]             out_flags,
  output logic [CWIDTH-1:0]      out_cmd,
  output logic                   out_mode,
  output logic                   out_timeout,
  output logic [$clog2(DEPTH):0] fill,
  output logic [7:0]             drop_cnt,
  output logic                   overflow
);

  localparam int unsigned NumSlots = 3;
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CWIDTH-1:0] lcmd_q, lcmd_d;
  logic            lmode_q, lmode_d;
  slot_t           slot_q [NumSlots];
  slot_t           slot_d [NumSlots];
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  logic            sched;
  logic [1:0]      sched_lat;
  logic [CWIDTH-1:0] sched_cmd;
  logic            sched_mode, sched_to;
  logic            coll_drop, fifo_drop;
  logic            push, pop, fifo_full, fifo_empty;
  alu_rec_t        push_rec, head_rec;
  logic [8:0]      drop_sum;

  // Issue / wait FSM: decides whether and with what tag a capture is scheduled.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lcmd_d     = lcmd_q;
    lmode_d    = lmode_q;
    sched      = 1'b0;
    sched_lat  = 2'd1;
    sched_cmd  = CMD;
    sched_mode = MODE;
    sched_to   = 1'b0;
    case (state_q)
      StIdle: begin
        if (CE && INP_VALID != 2'b00) begin
          if (INP_VALID == 2'b11 || !is_two_op(MODE, CMD)) begin
            sched     = 1'b1;
            sched_lat = op_latency(MODE, CMD);
          end else begin
            state_d    = StWait;
            wait_cnt_d = '0;
            lcmd_d     = CMD;
            lmode_d    = MODE;
          end
        end
      end
      StWait: begin
        sched_cmd  = lcmd_q;
        sched_mode = lmode_q;
        if (CE) begin
          if (INP_VALID == 2'b11) begin
            sched     = 1'b1;
            sched_lat = op_latency(lmode_q, lcmd_q);
            state_d   = StIdle;
          end else begin
            wait_cnt_d = wait_cnt_q + TW'(1);
            // The ALU flags ERR itself; we only record that the wait expired.
            if (wait_cnt_d == TimeoutVal) begin
              sched    = 1'b1;
              sched_to = 1'b1;
              state_d  = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Delay line: shift toward slot 0 and insert the new capture unless its slot is taken.
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      slot_d[i] = (i < NumSlots - 1) ? slot_q[i+1] : '0;
    end
    coll_drop = 1'b0;
    if (sched) begin
      if (slot_d[sched_lat - 2'd1].valid) begin
        coll_drop = 1'b1;
      end else begin
        slot_d[sched_lat - 2'd1] = '{valid: 1'b1, cmd: sched_cmd, mode: sched_mode,
                                    timeout: sched_to};
      end
    end
  end

  assign push     = slot_q[0].valid;
  assign push_rec = '{res: RES, flags: {COUT, OFLOW, E, G, L, ERR}, cmd: slot_q[0].cmd,
                      mode: slot_q[0].mode, timeout: slot_q[0].timeout};
  assign pop       = out_valid && out_ready;
  assign fifo_drop = push && fifo_full && !pop;

  // Drop accounting; a collision and a full-FIFO drop can land in the same cycle.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 9'(coll_drop) + 9'(fifo_drop);
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overflow_d = overflow_q | coll_drop | fifo_drop;
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      lcmd_q     <= '0;
      lmode_q    <= 1'b0;
      for (int i = 0; i < NumSlots; i++) slot_q[i] <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lcmd_q     <= lcmd_d;
      lmode_q    <= lmode_d;
      for (int i = 0; i < NumSlots; i++) slot_q[i] <= slot_d[i];
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  alu_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fill)
  );

  assign out_valid   = !fifo_empty;
  assign out_res     = head_rec.res;
  assign out_flags   = head_rec.flags;
  assign out_cmd     = head_rec.cmd;
  assign out_mode    = head_rec.mode;
  assign out_timeout = head_rec.timeout;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic,
// all compared every cycle against a cycle-indexed reference model.
module tb_alu_result_collector;

  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic clk, rst, ce, mode, out_ready;
  logic [CW-1:0] cmd;
  logic [1:0] iv;
  logic [W+1:0] res;
  logic cout, oflow, e, g, l, err;
  logic out_valid, out_mode, out_timeout, overflow;
  logic [W+1:0] out_res;
  logic [5:0] out_flags;
  logic [CW-1:0] out_cmd;
  logic [$clog2(DEPTH):0] fill;
  logic [7:0] drop_cnt;

  alu_result_collector #(
    .WIDTH(W), .CWIDTH(CW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(clk), .RST(rst), .CE(ce), .MODE(mode), .CMD(cmd), .INP_VALID(iv), .RES(res),
    .COUT(cout), .OFLOW(oflow), .E(e), .G(g), .L(l), .ERR(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_flags(out_flags),
    .out_cmd(out_cmd), .out_mode(out_mode), .out_timeout(out_timeout), .fill(fill),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W+1:0] res;
    logic [5:0] flags;
    logic [CW-1:0] cmd;
    logic mode;
    logic to;
  } exp_t;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic mode;
    logic to;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend[int];   // keyed by the absolute cycle in which RES is sampled
  int cyc = 0;
  bit waiting = 0;
  int wcnt = 0;
  logic [CW-1:0] wcmd;
  logic wmode;
  int m_drop = 0;
  bit m_ovf = 0;

  function automatic bit two_op(input logic md, input logic [CW-1:0] c);
    if (md) return c inside {0, 1, 2, 3, 8, 9, 10};
    return c inside {0, 1, 2, 3, 4, 5, 12, 13};
  endfunction

  function automatic int lat(input logic md, input logic [CW-1:0] c);
    return (md && (c == 9 || c == 10)) ? 3 : 1;
  endfunction

  task automatic note_drop();
    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    m_ovf  = 1;
  endtask

  task automatic schedule(input int at, input logic [CW-1:0] c, input logic md, input logic to);
    pend_t p;
    if (pend.exists(at)) note_drop();
    else begin
      p.cmd = c; p.mode = md; p.to = to;
      pend[at] = p;
    end
  endtask

  task automatic model_step();
    int c;
    exp_t r;
    c = cyc;
    cyc++;
    if (rst) begin
      exp_q.delete(); pend.delete();
      waiting = 0; wcnt = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    if (pend.exists(c)) begin
      r.res = res; r.flags = {cout, oflow, e, g, l, err};
      r.cmd = pend[c].cmd; r.mode = pend[c].mode; r.to = pend[c].to;
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else note_drop();
      pend.delete(c);
    end
    if (!ce) return;
    if (!waiting) begin
      if (iv == 2'b11 || (iv != 2'b00 && !two_op(mode, cmd))) schedule(c + lat(mode, cmd), cmd, mode, 0);
      else if (iv != 2'b00) begin
        waiting = 1; wcnt = 0; wcmd = cmd; wmode = mode;
      end
    end else if (iv == 2'b11) begin
      schedule(c + lat(wmode, wcmd), wcmd, wmode, 0);
      waiting = 0;
    end else begin
      wcnt++;
      if (wcnt == TIMEOUT) begin
        schedule(c + 1, wcmd, wmode, 1);
        waiting = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("fill", fill, exp_q.size());
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      if (exp_q.size() > 0) begin
        chk("out_res", out_res, exp_q[0].res);
        chk("out_flags", out_flags, exp_q[0].flags);
        chk("out_cmd", out_cmd, exp_q[0].cmd);
        chk("out_mode", out_mode, exp_q[0].mode);
        chk("out_timeout", out_timeout, exp_q[0].to);
      end else begin
        chk("idle_head", {out_res, out_flags, out_cmd, out_mode, out_timeout}, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic c_e, input logic md, input logic [CW-1:0] c, input logic [1:0] v);
    ce = c_e; mode = md; cmd = c; iv = v;
  endtask

  task automatic idle();
    drive(1, 0, 0, 2'b00);
  endtask

  task automatic rst_pulse();
    rst = 1; tick(); rst = 0;
  endtask

  int found;

  initial begin
    rst = 1; out_ready = 1; res = 0;
    {cout, oflow, e, g, l, err} = 6'b0;
    idle();
    repeat (3) tick();
    rst = 0;
    cmp_en = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ovf", overflow, 0);

    // Single-cycle op: result appears two cycles after issue.
    drive(1, 1, 0, 2'b11); res = 10'h3FF; tick();
    idle(); res = 10'h02A; tick();
    res = 0;
    chk("t1_valid", out_valid, 1);
    chk("t1_res", out_res, 10'h02A);
    chk("t1_cmd", out_cmd, 0);
    chk("t1_to", out_timeout, 0);
    tick();

    // Multiply at t and single-cycle op at t+2 collide on the same capture cycle.
    drive(1, 1, 9, 2'b11); tick();
    idle(); tick();
    drive(1, 1, 1, 2'b11); tick();
    idle(); tick();
    chk("coll_valid", out_valid, 1);
    chk("coll_cmd", out_cmd, 9);
    chk("coll_drop", drop_cnt, 1);
    chk("coll_ovf", overflow, 1);
    tick();
    chk("coll_single", out_valid, 0);
    rst_pulse();
    chk("coll_rst_drop", drop_cnt, 0);

    // Missing second operand: timeout after 16 CE cycles.
    drive(1, 0, 12, 2'b01); tick();
    for (int i = 0; i < TIMEOUT; i++) begin drive(1, 0, 5, 2'b00); tick(); end
    chk("to_early", out_valid, 0);
    idle(); res = 10'h155; err = 1; tick();
    err = 0; res = 0;
    chk("to_valid", out_valid, 1);
    chk("to_flag", out_timeout, 1);
    chk("to_cmd", out_cmd, 12);
    chk("to_res", out_res, 10'h155);
    chk("to_flags", out_flags, 6'b000001);
    tick();

    // Second operand arrives at cycle 5: normal capture of the latched command.
    drive(1, 0, 12, 2'b01); tick();
    repeat (4) begin idle(); tick(); end
    drive(1, 0, 3, 2'b11); tick();
    idle(); res = 10'h0AA; tick();
    res = 0;
    chk("late_valid", out_valid, 1);
    chk("late_cmd", out_cmd, 12);
    chk("late_to", out_timeout, 0);
    chk("late_res", out_res, 10'h0AA);
    tick();

    // Fill the FIFO with the consumer stalled: ninth capture is dropped.
    out_ready = 0;
    for (int j = 0; j < 9; j++) begin drive(1, 0, 6, 2'b01); res = 10'(j); tick(); end
    idle(); res = 10'd9; tick();
    res = 0; tick(); tick();
    chk("full_fill", fill, DEPTH);
    chk("full_drop", drop_cnt, 1);
    out_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_res", out_res, 10'(k + 1));
      tick();
    end
    chk("drain_empty", out_valid, 0);
    rst_pulse();

    // Reset while waiting with two captures in flight.
    drive(1, 1, 10, 2'b11); tick();
    drive(1, 1, 9, 2'b11); tick();
    drive(1, 0, 12, 2'b01); tick();
    idle(); rst_pulse();
    for (int k = 0; k < 20; k++) begin
      chk("rstwait_valid", out_valid, 0);
      tick();
    end
    chk("rstwait_fill", fill, 0);
    chk("rstwait_drop", drop_cnt, 0);

    // CE low for 5 cycles during the wait delays the timeout capture by 5.
    drive(1, 0, 12, 2'b01); tick();
    found = -1;
    for (int j = 1; j <= 40; j++) begin
      if (out_valid) begin found = j; break; end
      drive((j < 4 || j > 8), 0, 0, 2'b00); tick();
    end
    chk("ce_stall_cycle", found, 23);
    idle(); tick(); tick();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      ce = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom);
      cmd = CW'($urandom);
      iv = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
      res = 10'($urandom);
      {cout, oflow, e, g, l, err} = 6'($urandom);
      out_ready = (n % 500 < 150) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      tick();
    end
    rst = 0; idle(); out_ready = 1;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the ALU. Watches the ALU issue-side inputs and tracks per-command latency.
- Captures each ALU result on the cycle it becomes valid and tags it with its CMD/MODE.
- Buffers tagged results in a small FIFO and presents them on a valid/ready stream to the scoreboard or next pipeline stage.
- Also flags second-operand timeouts and any capture collisions or drops.

Parameters:
- WIDTH, 8, operand width; RES is WIDTH+2 bits.
- CWIDTH, 4, CMD width.
- DEPTH, 8, result FIFO depth; must be a power of 2, at least 2.
- TIMEOUT, 16, cycles to wait for the missing operand before the ALU raises ERR.

Ports:
- CLK, in, 1: clock, all logic on posedge.
- RST, in, 1: synchronous, active-high reset.
- CE, in, 1: ALU clock enable, observed.
- MODE, in, 1: 1 = arithmetic, 0 = logical.
- CMD, in, CWIDTH: ALU command.
- INP_VALID, in, 2: operand-valid bits, {OPB, OPA}.
- RES, in, WIDTH+2: ALU result.
- COUT, OFLOW, E, G, L, ERR, in, 1 each: ALU flags.
- out_valid, out, 1: FIFO head valid.
- out_ready, in, 1: consumer accepts the head.
- out_res, out, WIDTH+2: captured RES.
- out_flags, out, 6: {COUT, OFLOW, E, G, L, ERR}.
- out_cmd, out, CWIDTH: tag.
- out_mode, out, 1: tag.
- out_timeout, out, 1: this entry is a timeout capture.
- fill, out, $clog2(DEPTH)+1: FIFO occupancy.
- drop_cnt, out, 8: saturating count of dropped captures.
- overflow, out, 1: sticky; set on any drop.

Behaviour:
- Reset: RST=1 at a posedge clears all state. Every output is 0 the following cycle. Pending captures and the wait counter are discarded. This applies mid-operation too.
- Two-operand commands:
  - MODE=1: CMD in {0,1,2,3,8,9,10}.
  - MODE=0: CMD in {0,1,2,3,4,5,12,13}.
  - All other commands are single-operand.
- Issue event, evaluated only when CE=1 and the FSM is IDLE:
  - INP_VALID=11, any command: issue.
  - INP_VALID=01 or 10 with a single-operand command: issue.
  - INP_VALID=01 or 10 with a two-operand command: go to WAIT, latching CMD and MODE.
  - INP_VALID=00: no issue, no capture.
- Latency: issue at cycle t schedules a capture at t+3 for MODE=1 with CMD 9 or 10, otherwise at t+1.
- Capture scheduling: a 3-slot delay line; each slot holds {valid, cmd, mode, timeout}.
- FSM states:
  - IDLE: issue events as above.
  - WAIT: wait counter increments every CE=1 cycle and freezes when CE=0. INP_VALID=11 while CE=1 issues the latched CMD/MODE with the normal latency and returns to IDLE. When the counter reaches TIMEOUT, schedule a capture at +1 with timeout=1 and return to IDLE.
  - Only one outstanding wait is allowed.
- Capture: when slot 0 is valid, sample RES and the flags that cycle and push {RES, flags, cmd, mode, timeout}.
- Collision: if an issue targets a slot that is already valid, the earlier-scheduled entry is kept, the new one is dropped, drop_cnt increments and overflow is set.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push when full is allowed only if a pop occurs in the same cycle. Otherwise the capture is dropped, drop_cnt increments and overflow is set.
  - Simultaneous push and pop when empty: the entry is written and out_valid asserts the next cycle; there is no bypass.
  - Head data is stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. fill ranges 0..DEPTH. drop_cnt saturates at 255.
- CE=0 blocks new issue only; already-scheduled captures still complete.

Decomposition:
- alu_pkg:
  - typedef alu_rec_t {res, flags, cmd, mode, timeout};
  - constants for multiply CMDs (9, 10) and the two-operand CMD sets;
  - function is_two_op(mode, cmd);
  - function op_latency(mode, cmd).
- Sub-module alu_rec_fifo: a parameterised sync FIFO of alu_rec_t with push, pop, full, empty and fill.
- The top level holds the FSM, the delay line and the drop accounting.

Test Plan:
- MODE=1, CMD=0, INP_VALID=11, CE=1 at t; RES=0x2A at t+1 -> out_valid at t+2 with out_res=0x2A, out_cmd=0, out_timeout=0.
- MODE=1, CMD=9 at t, then CMD=1 at t+2 -> both target t+3; one entry {cmd=9} is captured, drop_cnt=1, overflow=1.
- MODE=0, CMD=12, INP_VALID=01, then 00 for 16 CE cycles -> one entry with out_timeout=1 and ERR sampled. Repeat with 11 arriving at cycle 5 -> normal capture, timeout=0.
- DEPTH=8, out_ready=0, 9 back-to-back MODE=0 CMD=6 issues -> fill=8, drop_cnt=1. Then out_ready=1 -> 8 entries drain in issue order.
- RST=1 for one cycle while in WAIT with 2 slots pending -> no captures follow, fill=0, drop_cnt=0, out_valid=0.
- CE=0 for 5 cycles inside WAIT -> the timeout capture is delayed by exactly 5 cycles.
